// File: rtl/pdm_frame_scheduler.sv
// rtl/pdm_frame_scheduler.sv - PDM clock/strobe generator and per-frame CIC snapshot serialiser
module pdm_frame_scheduler #(
    parameter int NCH      = 8,
    parameter int PDM_HALF = 16,
    parameter int DEC      = 64,
    parameter int SETTLE   = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     enable,
    output logic                     pdm_clk,
    output logic                     bit_stb,
    output logic                     dec_stb,
    input  logic [16*NCH-1:0]        cic_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [15:0]              out_data,
    output logic [$clog2(NCH)-1:0]   out_chan,
    output logic                     out_first,
    output logic                     overrun,
    output logic [7:0]               overrun_cnt
);

    localparam int PW = $clog2(2*PDM_HALF);
    localparam int BW = $clog2(DEC);
    localparam int CW = $clog2(NCH);
    localparam int SW = 16;

    localparam logic [PW-1:0] PH_HALF = PW'(PDM_HALF);
    localparam logic [PW-1:0] PH_LAST = PW'(2*PDM_HALF-1);
    localparam logic [BW-1:0] B_LAST  = BW'(DEC-1);
    localparam logic [CW-1:0] C_LAST  = CW'(NCH-1);
    localparam logic [SW-1:0] S_LAST  = SW'(SETTLE-1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SETTLE,
        S_WAIT,
        S_SEND
    } state_t;

    state_t                 state;
    logic [PW-1:0]          ph;
    logic [PW-1:0]          ph_n;
    logic [BW-1:0]          bcnt;
    logic [SW-1:0]          scnt;
    logic                   snap;
    logic [CW-1:0]          chan_n;
    logic [NCH-1:0][15:0]   frame;

    always_comb begin
        ph_n   = (ph == PH_LAST) ? '0 : ph + 1'b1;
        chan_n = out_chan + 1'b1;
    end

    // pdm_clk/bit_stb are registered from the next phase so they line up with ph.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= S_IDLE;
            ph          <= '0;
            bcnt        <= '0;
            scnt        <= '0;
            snap        <= 1'b0;
            frame       <= '0;
            pdm_clk     <= 1'b0;
            bit_stb     <= 1'b0;
            dec_stb     <= 1'b0;
            out_valid   <= 1'b0;
            out_data    <= '0;
            out_chan    <= '0;
            out_first   <= 1'b0;
            overrun     <= 1'b0;
            overrun_cnt <= '0;
        end else if (!enable) begin
            // Abort everything except the overrun record, which survives until re-enable.
            state     <= S_IDLE;
            ph        <= '0;
            bcnt      <= '0;
            scnt      <= '0;
            snap      <= 1'b0;
            pdm_clk   <= 1'b0;
            bit_stb   <= 1'b0;
            dec_stb   <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_chan  <= '0;
            out_first <= 1'b0;
        end else if (state == S_IDLE) begin
            state       <= (SETTLE == 0) ? S_WAIT : S_SETTLE;
            overrun     <= 1'b0;
            overrun_cnt <= '0;
        end else begin
            ph      <= ph_n;
            pdm_clk <= (ph_n >= PH_HALF);
            bit_stb <= (ph_n == PH_LAST);
            if (ph == PH_LAST) begin
                bcnt <= (bcnt == B_LAST) ? '0 : bcnt + 1'b1;
            end
            dec_stb <= (ph == PH_LAST) && (bcnt == B_LAST);
            snap    <= dec_stb;

            case (state)
                S_SETTLE: begin
                    // Warm-up frames are counted on the snapshot so the last discarded one is not sent.
                    if (snap) begin
                        if (scnt == S_LAST) begin
                            state <= S_WAIT;
                            scnt  <= '0;
                        end else begin
                            scnt <= scnt + 1'b1;
                        end
                    end
                end
                S_WAIT: begin
                    if (snap) begin
                        frame     <= cic_data;
                        out_valid <= 1'b1;
                        out_chan  <= '0;
                        out_data  <= cic_data[15:0];
                        out_first <= 1'b1;
                        state     <= S_SEND;
                    end
                end
                S_SEND: begin
                    if (snap) begin
                        overrun <= 1'b1;
                        if (overrun_cnt != 8'hFF) begin
                            overrun_cnt <= overrun_cnt + 8'd1;
                        end
                    end
                    if (out_valid && out_ready) begin
                        out_first <= 1'b0;
                        if (out_chan == C_LAST) begin
                            out_valid <= 1'b0;
                            state     <= S_WAIT;
                        end else begin
                            out_chan <= chan_n;
                            out_data <= frame[chan_n];
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pdm_frame_scheduler.sv
// tb/tb_pdm_frame_scheduler.sv - directed self-checking bench for pdm_frame_scheduler
module tb_pdm_frame_scheduler;

    logic        clk;
    logic        rst;
    logic        enable;
    logic        pdm_clk;
    logic        bit_stb;
    logic        dec_stb;
    logic [63:0] cic_data;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_data;
    logic [1:0]  out_chan;
    logic        out_first;
    logic        overrun;
    logic [7:0]  overrun_cnt;

    int checks;
    int errors;
    int cyc;
    int base;
    int words;
    int exp_chan;

    pdm_frame_scheduler #(
        .NCH(4),
        .PDM_HALF(2),
        .DEC(4),
        .SETTLE(2)
    ) dut (
        .clk(clk),
        .rst(rst),
        .enable(enable),
        .pdm_clk(pdm_clk),
        .bit_stb(bit_stb),
        .dec_stb(dec_stb),
        .cic_data(cic_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data(out_data),
        .out_chan(out_chan),
        .out_first(out_first),
        .overrun(overrun),
        .overrun_cnt(overrun_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s at cyc %0d: observed %0h expected %0h", tag, cyc, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic run_to(input int n);
        while (cyc < n) tick();
    endtask

    task automatic check_word(input string tag, input logic [15:0] d, input logic [1:0] c);
        check({tag, "_valid"}, 32'(out_valid), 32'd1);
        check({tag, "_data"}, 32'(out_data), 32'(d));
        check({tag, "_chan"}, 32'(out_chan), 32'(c));
        check({tag, "_first"}, 32'(out_first), 32'(c == 2'd0));
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        cyc       = 0;
        rst       = 1'b1;
        enable    = 1'b0;
        out_ready = 1'b1;
        cic_data  = {16'h4444, 16'h3333, 16'h2222, 16'h1111};
        repeat (3) tick();
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_pdm", 32'(pdm_clk), 32'd0);
        check("rst_cnt", 32'(overrun_cnt), 32'd0);
        rst = 1'b0;
        repeat (2) tick();
        check("idle_pdm", 32'(pdm_clk), 32'd0);

        // Scenario 1/2: timing pattern and suppression of two warm-up frames
        cyc    = 0;
        enable = 1'b1;
        for (int c = 1; c <= 50; c++) begin
            tick();
            if (c <= 34) begin
                check("pdm_clk", 32'(pdm_clk), 32'(((c - 1) % 4) >= 2));
                check("bit_stb", 32'(bit_stb), 32'(((c - 1) % 4) == 3));
                check("dec_stb", 32'(dec_stb), 32'((c > 1) && ((c % 16) == 1)));
            end
            check("settle_novalid", 32'(out_valid), 32'd0);
        end
        tick();
        check_word("f1w0", 16'h1111, 2'd0);
        tick();
        check_word("f1w1", 16'h2222, 2'd1);
        tick();
        check_word("f1w2", 16'h3333, 2'd2);
        tick();
        check_word("f1w3", 16'h4444, 2'd3);
        tick();
        check("f1_done", 32'(out_valid), 32'd0);

        // Scenario 3: stall across two snapshots
        out_ready = 1'b0;
        cic_data  = {16'h8888, 16'h7777, 16'h6666, 16'h5555};
        run_to(67);
        check_word("stall_start", 16'h5555, 2'd0);
        cic_data = {16'hDDDD, 16'hCCCC, 16'hBBBB, 16'hAAAA};
        run_to(80);
        check_word("stall_hold", 16'h5555, 2'd0);
        run_to(82);
        check("ovr_before", 32'(overrun), 32'd0);
        tick();
        check("ovr_set", 32'(overrun), 32'd1);
        check("ovr_cnt1", 32'(overrun_cnt), 32'd1);
        run_to(107);
        check_word("stall_end", 16'h5555, 2'd0);
        check("ovr_cnt2", 32'(overrun_cnt), 32'd2);
        out_ready = 1'b1;
        tick();
        check_word("rel_w1", 16'h6666, 2'd1);
        tick();
        tick();
        check_word("rel_w3", 16'h8888, 2'd3);
        tick();
        check("rel_done", 32'(out_valid), 32'd0);
        run_to(115);
        check_word("f3w0", 16'hAAAA, 2'd0);
        run_to(119);
        check("f3_done", 32'(out_valid), 32'd0);

        // Scenario 4: 50% ready duty, four frames, no extra overruns
        words    = 0;
        exp_chan = 0;
        for (int i = 0; i < 72; i++) begin
            out_ready = i[0];
            if (out_valid && out_ready) begin
                check("duty_chan", 32'(out_chan), 32'(exp_chan));
                check("duty_data", 32'(out_data), 32'(16'hAAAA + 16'(exp_chan) * 16'h1111));
                check("duty_first", 32'(out_first), 32'(exp_chan == 0));
                exp_chan = (exp_chan + 1) % 4;
                words++;
            end
            tick();
        end
        check("duty_words", 32'(words), 32'd16);
        check("duty_cnt", 32'(overrun_cnt), 32'd2);

        // Scenario 5: drop enable with chan 2 pending, then re-enable
        out_ready = 1'b1;
        run_to(195);
        check_word("ab_w0", 16'hAAAA, 2'd0);
        run_to(197);
        check_word("ab_w2", 16'hCCCC, 2'd2);
        out_ready = 1'b0;
        enable    = 1'b0;
        tick();
        check("ab_valid", 32'(out_valid), 32'd0);
        check("ab_pdm", 32'(pdm_clk), 32'd0);
        check("ab_bit", 32'(bit_stb), 32'd0);
        check("ab_ovr_hold", 32'(overrun), 32'd1);
        check("ab_cnt_hold", 32'(overrun_cnt), 32'd2);
        out_ready = 1'b1;
        run_to(200);
        enable = 1'b1;
        tick();
        check("reen_ovr", 32'(overrun), 32'd0);
        check("reen_cnt", 32'(overrun_cnt), 32'd0);
        while (cyc < 250) begin
            tick();
            check("reen_novalid", 32'(out_valid), 32'd0);
        end
        tick();
        check_word("reen_w0", 16'hAAAA, 2'd0);
        tick();
        check_word("reen_w1", 16'hBBBB, 2'd1);

        // Scenario 6: asynchronous reset mid-SEND, then saturation of drop count
        #1;
        rst       = 1'b1;
        out_ready = 1'b0;
        #1;
        check("arst_valid", 32'(out_valid), 32'd0);
        check("arst_data", 32'(out_data), 32'd0);
        check("arst_chan", 32'(out_chan), 32'd0);
        check("arst_pdm", 32'(pdm_clk), 32'd0);
        tick();
        rst  = 1'b0;
        base = cyc;
        run_to(base + 51);
        check_word("sat_w0", 16'hAAAA, 2'd0);
        run_to(base + 50 + 255 * 16);
        check("sat_254", 32'(overrun_cnt), 32'd254);
        tick();
        check("sat_255", 32'(overrun_cnt), 32'd255);
        run_to(base + 51 + 300 * 16 + 6);
        check("sat_hold", 32'(overrun_cnt), 32'd255);
        check("sat_ovr", 32'(overrun), 32'd1);
        check_word("sat_frame", 16'hAAAA, 2'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
